maxpool_rd_sched: RTL and testbench
===================================

# maxpool_rd_sched

Read-side scheduler for the 26×26 first-convolution result memory. On `start` it drives that memory's `ren`/`radd` port through every non-overlapping 2×2 window, one read per cycle with no bubbles. It reduces each window to its signed maximum and streams 13×13 pooled results with a destination address. It sits between the conv-1 result memory and the max-pool result memory in the SoC CNN pipeline.

## Interface
Parameters:
- `N_C`, 26, columns of the conv result image (must be even)
- `N_R`, 26, rows of the conv result image (must be even)
- `DATA_W`, 8, signed sample width
- `ADDR_W`, 10, conv memory address width (N_C·N_R ≤ 2^ADDR_W)
- `OUT_ADDR_W`, 8, pooled-result address width ((N_C/2)·(N_R/2) ≤ 2^OUT_ADDR_W)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` in 1: sole clock, rising edge
  - `rst_n` in 1: asynchronous active-low reset
- `start` in 1: one-cycle request to pool the whole image
- `busy` out 1: high while a pass is in progress
- `done` out 1: one-cycle pulse at end of pass
- `mem_ren` out 1: read enable to conv result memory
- `mem_radd` out ADDR_W: read address to conv result memory
- `mem_rdata` in DATA_W: registered read data, valid the cycle after `mem_ren`; interpreted as signed
- `out_valid` out 1: pooled sample valid, one-cycle pulse per window
- `out_data` out DATA_W: signed window maximum
- `out_addr` out OUT_ADDR_W: pooled index r·(N_C/2)+c

## Operation
- FSM states:
  - IDLE
  - READ: issues reads
  - FLUSH: last data and last result
  - DONE
- IDLE→READ when `start`=1.
- `start` is ignored outside IDLE.
- Counters:
  - window row `r` (0..N_R/2−1)
  - window col `c` (0..N_C/2−1)
  - phase `p` (0..3)
- Phase p=0,1,2,3 address: (2r)·N_C+2c, (2r)·N_C+2c+1, (2r+1)·N_C+2c, (2r+1)·N_C+2c+1.
- Address computed in ADDR_W bits; no wrap for legal parameters.
- Iteration order: p fastest, then c, then r.
- READ→FLUSH after the phase-3 read of the final window (r=N_R/2−1, c=N_C/2−1).
- FLUSH lasts 2 cycles, then DONE.
- DONE lasts 1 cycle, then IDLE.
- Reduction: a delayed copy of phase/valid tracks the memory's 1-cycle latency.
  - Phase-0 data loads the accumulator.
  - Phases 1–3 keep the signed maximum (ties keep the current value).
  - Phase-3 result registers into `out_data`.
- `out_addr` increments 0..(N_C/2)(N_R/2)−1 and resets to 0 on every accepted `start`.
- Reset (asynchronous, any time, including mid-pass):
  - state IDLE; all counters 0.
  - `busy`, `done`, `mem_ren`, `out_valid` = 0.
  - `mem_radd`, `out_data`, `out_addr` = 0.
  - The partial pass is discarded; no `done` is produced.

## Timing
- Cycle 0 = first cycle after the edge that samples `start`.
- `busy`=1 and `mem_ren`=1 from cycle 0. `mem_ren` is continuous for 4·W cycles, W=(N_C/2)(N_R/2) (676 cycles at defaults).
- Read k is issued in cycle k; its data is valid in cycle k+1.
- Window w's `out_valid` is high in cycle 4w+5 (first at cycle 5, last at cycle 677 at defaults).
- `done`=1 in cycle 4W+2 (678). `busy` falls in the same cycle.
- Earliest next accepted `start` is sampled at the edge ending the `done` cycle.
- `mem_radd` holds its last value when `mem_ren`=0.

## Configuration
- `MAXPOOL_RELU_EN`
  - Defined: `out_data` = max(window max, 0). Negative windows emit 0. Timing is unchanged.
  - Undefined: `out_data` is the raw signed maximum.

## Structure
- Package `maxpool_pkg`:
  - FSM state enum
  - phase offset constants {0, 1, N_C, N_C+1}
  - `W_OUT` = (N_C/2)(N_R/2)
- Sub-module `maxpool_addr_gen`:
  - r/c/p counters and `mem_radd` computation
  - `last` flag
- Parent holds the FSM, the latency-matched reduction and the output registers.

## Test plan
- **Ramp:** memory loaded with value = addr mod 128, then `start`.
  - First `out_data` = 27 at `out_addr` 0, in cycle 5.
  - Window (0,1) emits 29.
  - 169 `out_valid` pulses total.
  - `done` in cycle 678.
- **Negatives:** window 0 = {−5, −3, −128, −7} → `out_data` = −3 (0xFD). With `MAXPOOL_RELU_EN` → 0.
- **Ties/extremes:**
  - window {127, 127, −128, 0} → 127.
  - all −128 → −128 (0x80).
- **`start` while busy:** pulse `start` at cycle 100 → ignored.
  - Exactly 169 outputs.
  - Single `done`.
  - Address sequence unchanged.
- **Reset mid-pass:** assert `rst_n`=0 at cycle 300.
  - All outputs go to 0 immediately.
  - No `done`.
  - A new `start` restarts at `mem_radd` 0, `out_addr` 0.
- **Back-to-back:** `start` in the `done` cycle → second pass is bubble-free and produces identical output.

Source files
------------

// File: rtl/maxpool_pkg.sv
// Shared types and constants for the conv-1 max-pool read scheduler.
// Contents: FSM state enum, default image geometry, pooled-window count,
// and the per-phase address offset helper {0, 1, N_C, N_C+1}.
package maxpool_pkg;

  localparam int unsigned N_C_DEF = 26;
  localparam int unsigned N_R_DEF = 26;
  localparam int unsigned W_OUT   = (N_C_DEF / 2) * (N_R_DEF / 2);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Offset of each 2x2 window phase from the window's top-left sample.
  function automatic int unsigned phase_off(input logic [1:0] p, input int unsigned n_c);
    case (p)
      2'd0:    return 0;
      2'd1:    return 1;
      2'd2:    return n_c;
      default: return n_c + 1;
    endcase
  endfunction

endpackage

// File: rtl/maxpool_addr_gen.sv
// Window address generator: walks phase p (fastest), window column c, then
// window row r, and registers the matching conv-memory read address.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   load        - restart at window (0,0) phase 0
//   step        - advance to the next read
//   phase       - phase of the read currently on mem_radd
//   last_c      - current read is phase 3 of the final window
//   mem_radd    - registered read address (holds when not stepping)
module maxpool_addr_gen
  import maxpool_pkg::*;
#(
  parameter int unsigned N_C    = N_C_DEF,
  parameter int unsigned N_R    = N_R_DEF,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  output logic [1:0]        phase,
  output logic              last_c,
  output logic [ADDR_W-1:0] mem_radd
);

  localparam int unsigned N_WC = N_C / 2;
  localparam int unsigned N_WR = N_R / 2;
  localparam int unsigned C_W  = (N_WC > 1) ? $clog2(N_WC) : 1;
  localparam int unsigned R_W  = (N_WR > 1) ? $clog2(N_WR) : 1;

  logic [C_W-1:0]    c_q, c_d;
  logic [R_W-1:0]    r_q, r_d;
  logic [1:0]        p_d;
  logic [ADDR_W-1:0] radd_d;

  assign last_c = (phase == 2'd3) && (c_q == C_W'(N_WC - 1)) && (r_q == R_W'(N_WR - 1));

  // Next counter values; the FSM never steps past the final read.
  always_comb begin
    p_d = phase;
    c_d = c_q;
    r_d = r_q;
    if (load) begin
      p_d = 2'd0;
      c_d = '0;
      r_d = '0;
    end else if (step) begin
      p_d = phase + 2'd1;
      if (phase == 2'd3) begin
        if (c_q == C_W'(N_WC - 1)) begin
          c_d = '0;
          r_d = r_q + R_W'(1);
        end else begin
          c_d = c_q + C_W'(1);
        end
      end
    end
  end

  // Address of the read selected by the next counter values.
  always_comb begin
    radd_d = ADDR_W'(2 * N_C * 32'(r_d) + 2 * 32'(c_d) + phase_off(p_d, N_C));
  end

  // Counters and address register advance together, so phase always
  // describes the read currently presented on mem_radd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase    <= 2'd0;
      c_q      <= '0;
      r_q      <= '0;
      mem_radd <= '0;
    end else if (load || step) begin
      phase    <= p_d;
      c_q      <= c_d;
      r_q      <= r_d;
      mem_radd <= radd_d;
    end
  end

endmodule

// File: rtl/maxpool_rd_sched.sv
// Read-side scheduler for the conv-1 result memory: streams every 2x2
// window through mem_ren/mem_radd with no bubbles, reduces each window to
// its signed maximum and emits one pooled sample per window.
// Build option: define MAXPOOL_RELU_EN to clamp negative maxima to 0.
// Ports:
//   clk, rst_n            - clock, async active-low reset
//   start                 - one-cycle pass request (IDLE or DONE only)
//   busy, done            - pass in progress / end-of-pass pulse
//   mem_ren, mem_radd     - conv memory read port
//   mem_rdata             - registered read data, one cycle after mem_ren
//   out_valid, out_data,
//   out_addr              - pooled sample stream
module maxpool_rd_sched
  import maxpool_pkg::*;
#(
  parameter int unsigned N_C        = N_C_DEF,
  parameter int unsigned N_R        = N_R_DEF,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 10,
  parameter int unsigned OUT_ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_ren,
  output logic [ADDR_W-1:0]     mem_radd,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_ADDR_W-1:0] out_addr
);

  state_e state_q, state_d;
  logic   fl_q, fl_d;
  logic   busy_d, done_d, ren_d;
  logic   load_c, step_c, last_c;
  logic [1:0] phase;

  maxpool_addr_gen #(
    .N_C    (N_C),
    .N_R    (N_R),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .step     (step_c),
    .phase    (phase),
    .last_c   (last_c),
    .mem_radd (mem_radd)
  );

  // Next state and next registered outputs. DONE accepts start so a new
  // pass can follow back-to-back.
  always_comb begin
    state_d = state_q;
    fl_d    = 1'b0;
    load_c  = 1'b0;
    step_c  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ren_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_READ;
          load_c  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (last_c) begin
          state_d = ST_FLUSH;
        end else begin
          step_c = 1'b1;
        end
      end
      ST_FLUSH: begin
        // Two cycles: last read data arrives, then the last result registers.
        if (fl_q) begin
          state_d = ST_DONE;
        end else begin
          fl_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_READ) || (state_d == ST_FLUSH);
    done_d = (state_d == ST_DONE);
    ren_d  = (state_d == ST_READ);
  end

  // FSM state and control output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      fl_q    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mem_ren <= 1'b0;
    end else begin
      state_q <= state_d;
      fl_q    <= fl_d;
      busy    <= busy_d;
      done    <= done_d;
      mem_ren <= ren_d;
    end
  end

  // Reduction datapath; vld_q/ph_q follow the memory's one-cycle latency.
  logic                         vld_q;
  logic [1:0]                   ph_q;
  logic signed [DATA_W-1:0]     acc_q;
  logic signed [DATA_W-1:0]     rdata_s;
  logic signed [DATA_W-1:0]     smax_c;
  logic signed [DATA_W-1:0]     res_c;
  logic [OUT_ADDR_W-1:0]        out_idx_q;

  assign rdata_s = $signed(mem_rdata);

  // Ties keep the accumulator: only a strictly larger sample replaces it.
  always_comb begin
    smax_c = (rdata_s > acc_q) ? rdata_s : acc_q;
`ifdef MAXPOOL_RELU_EN
    res_c = smax_c[DATA_W-1] ? '0 : smax_c;
`else
    res_c = smax_c;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= 1'b0;
      ph_q      <= 2'd0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_idx_q <= '0;
    end else begin
      vld_q     <= mem_ren;
      ph_q      <= phase;
      out_valid <= 1'b0;
      if (vld_q) begin
        case (ph_q)
          2'd0: acc_q <= rdata_s;
          2'd3: begin
            out_valid <= 1'b1;
            out_data  <= res_c;
            out_addr  <= out_idx_q;
            out_idx_q <= out_idx_q + OUT_ADDR_W'(1);
          end
          default: acc_q <= smax_c;
        endcase
      end
      if (load_c) begin
        out_addr  <= '0;
        out_idx_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_maxpool_rd_sched.sv
// Self-checking bench for maxpool_rd_sched: behavioural memory, window-max
// reference computed from the image contents, cycle-exact stream checks.
module tb_maxpool_rd_sched;

  localparam int NC    = 26;
  localparam int NR    = 26;
  localparam int NWC   = NC / 2;
  localparam int NW    = (NC / 2) * (NR / 2);
  localparam int NREAD = 4 * NW;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, mem_ren, out_valid;
  logic [9:0] mem_radd;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] out_data;
  logic [7:0] out_addr;

  int n_tests = 0;
  int n_fail  = 0;
  int cur_cyc = -1;

  logic [7:0] mem   [0:NC*NR-1];
  logic [7:0] exp_d [0:NW-1];
  logic [7:0] got_d [0:NW-1];
  logic [7:0] ref_d [0:NW-1];

  maxpool_rd_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .mem_ren   (mem_ren),
    .mem_radd  (mem_radd),
    .mem_rdata (mem_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_addr  (out_addr)
  );

  always #5 clk = ~clk;

  // Conv result memory with registered read data.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem[mem_radd];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cur_cyc, got, exp);
    end
  endtask

  // Maximum of the 2x2 block at window w, straight from the image.
  function automatic logic [7:0] win_max(input int w);
    int r, c, m, v;
    r = w / NWC;
    c = w % NWC;
    m = -1000;
    for (int dy = 0; dy < 2; dy++)
      for (int dx = 0; dx < 2; dx++) begin
        v = int'($signed(mem[(2*r + dy) * NC + 2*c + dx]));
        if (v > m) m = v;
      end
`ifdef MAXPOOL_RELU_EN
    if (m < 0) m = 0;
`endif
    return 8'(m);
  endfunction

  // Image address read in cycle k of a pass.
  function automatic int read_addr(input int k);
    int w, p;
    w = k / 4;
    p = k % 4;
    return (2 * (w / NWC) + p / 2) * NC + 2 * (w % NWC) + p % 2;
  endfunction

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_busy"},      32'(busy),      32'd0);
    check_eq({tag, "_done"},      32'(done),      32'd0);
    check_eq({tag, "_mem_ren"},   32'(mem_ren),   32'd0);
    check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_mem_radd"},  32'(mem_radd),  32'd0);
    check_eq({tag, "_out_data"},  32'(out_data),  32'd0);
    check_eq({tag, "_out_addr"},  32'(out_addr),  32'd0);
  endtask

  // One pass. inj_at: cycle to pulse a stray start; rst_at: cycle to reset;
  // chain: raise start in the done cycle and return for a back-to-back pass.
  task automatic run_pass(input int inj_at, input int rst_at, input bit chain);
    int  n_out, n_done, w;
    bit  exp_v;
    n_out  = 0;
    n_done = 0;
    if (!start) begin
      @(negedge clk);
      start = 1'b1;
    end
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < NW; i++) exp_d[i] = win_max(i);
    for (int cyc = 0; cyc <= NREAD + 5; cyc++) begin
      @(negedge clk);
      cur_cyc = cyc;
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        repeat (3) begin
          @(negedge clk);
          check_eq("midrst_hold_done", 32'(done), 32'd0);
          check_eq("midrst_hold_busy", 32'(busy), 32'd0);
        end
        rst_n = 1'b1;
        check_eq("midrst_no_done", 32'(n_done), 32'd0);
        return;
      end
      check_eq("busy",    32'(busy),    32'(cyc < NREAD + 2));
      check_eq("done",    32'(done),    32'(cyc == NREAD + 2));
      check_eq("mem_ren", 32'(mem_ren), 32'(cyc < NREAD));
      if (cyc <= NREAD + 2)
        check_eq("mem_radd", 32'(mem_radd), 32'(read_addr((cyc < NREAD) ? cyc : NREAD - 1)));
      exp_v = (cyc >= 5) && ((cyc - 5) % 4 == 0) && ((cyc - 5) / 4 < NW);
      check_eq("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        w = (cyc - 5) / 4;
        check_eq("out_data", 32'(out_data), 32'(exp_d[w]));
        check_eq("out_addr", 32'(out_addr), 32'(w));
        got_d[w] = out_data;
      end
      if (out_valid) n_out++;
      if (done) n_done++;
      if (cyc == inj_at) start = 1'b1;
      else if (cyc == inj_at + 1) start = 1'b0;
      if (chain && cyc == NREAD + 2) begin
        start = 1'b1;
        break;
      end
    end
    check_eq("n_out",  32'(n_out),  32'(NW));
    check_eq("n_done", 32'(n_done), 32'd1);
  endtask

  initial begin
    for (int a = 0; a < NC * NR; a++) mem[a] = 8'(a % 128);

    // Reset values while rst_n is held low.
    #2;
    check_zero_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_busy", 32'(busy), 32'd0);

    // Ramp image.
    run_pass(-1, -1, 1'b0);
    check_eq("ramp_w0", 32'(got_d[0]), 32'd27);
    check_eq("ramp_w1", 32'(got_d[1]), 32'd29);

    // Random image with negatives, ties and extremes; stray start at cycle 100.
    for (int a = 0; a < NC * NR; a++) mem[a] = 8'($urandom);
    mem[0]  = 8'hFB; mem[1]  = 8'hFD; mem[NC]     = 8'h80; mem[NC + 1] = 8'hF9;
    mem[2]  = 8'h7F; mem[3]  = 8'h7F; mem[NC + 2] = 8'h80; mem[NC + 3] = 8'h00;
    mem[4]  = 8'h80; mem[5]  = 8'h80; mem[NC + 4] = 8'h80; mem[NC + 5] = 8'h80;
    run_pass(100, -1, 1'b0);
`ifdef MAXPOOL_RELU_EN
    check_eq("neg_w0",  32'(got_d[0]), 32'h00);
    check_eq("min_w2",  32'(got_d[2]), 32'h00);
`else
    check_eq("neg_w0",  32'(got_d[0]), 32'hFD);
    check_eq("min_w2",  32'(got_d[2]), 32'h80);
`endif
    check_eq("tie_w1", 32'(got_d[1]), 32'h7F);

    // Reset mid-pass, then a clean restart from address 0.
    for (int a = 0; a < NC * NR; a++) mem[a] = 8'($urandom);
    run_pass(-1, 300, 1'b0);
    repeat (2) @(negedge clk);
    run_pass(-1, -1, 1'b0);

    // Back-to-back passes over the same image must match.
    for (int a = 0; a < NC * NR; a++) mem[a] = 8'($urandom);
    run_pass(-1, -1, 1'b1);
    for (int i = 0; i < NW; i++) ref_d[i] = got_d[i];
    run_pass(-1, -1, 1'b0);
    for (int i = 0; i < NW; i++) check_eq("b2b_same", 32'(got_d[i]), 32'(ref_d[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
